// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle between the multicycle controller and its datapath.
//                The datapath supplies the opcode and the memory handshake.
//                The controller returns the datapath control strobes and a
//                small set of status signals.
//  Ports       : Opcode[5:0], MemoryReady              (datapath -> control)
//                ALUOpcode, ALUSrcA, ALUSrcB, PCSource,
//                MemoryRead, MemoryWrite, RegisterWrite,
//                RegistroDestino, MemoryToRegister, IorD,
//                IRWrite, PCWrite, PCWriteCond         (control -> datapath)
//                Illegal, InstrDone, Retired, State    (status)
//  Modports    : master = controller, slave = datapath / environment
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
   parameter int RETIRED_W = 16
);
   // datapath -> controller
   logic [5:0]           Opcode;
   logic                 MemoryReady;

   // controller -> datapath
   logic [1:0]           ALUOpcode;
   logic                 ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [1:0]           PCSource;
   logic                 MemoryRead;
   logic                 MemoryWrite;
   logic                 RegisterWrite;
   logic                 RegistroDestino;
   logic                 MemoryToRegister;
   logic                 IorD;
   logic                 IRWrite;
   logic                 PCWrite;
   logic                 PCWriteCond;

   // status
   logic                 Illegal;
   logic                 InstrDone;
   logic [RETIRED_W-1:0] Retired;
   logic [3:0]           State;

   modport master (
      input  Opcode,
      input  MemoryReady,
      output ALUOpcode,
      output ALUSrcA,
      output ALUSrcB,
      output PCSource,
      output MemoryRead,
      output MemoryWrite,
      output RegisterWrite,
      output RegistroDestino,
      output MemoryToRegister,
      output IorD,
      output IRWrite,
      output PCWrite,
      output PCWriteCond,
      output Illegal,
      output InstrDone,
      output Retired,
      output State
   );

   modport slave (
      output Opcode,
      output MemoryReady,
      input  ALUOpcode,
      input  ALUSrcA,
      input  ALUSrcB,
      input  PCSource,
      input  MemoryRead,
      input  MemoryWrite,
      input  RegisterWrite,
      input  RegistroDestino,
      input  MemoryToRegister,
      input  IorD,
      input  IRWrite,
      input  PCWrite,
      input  PCWriteCond,
      input  Illegal,
      input  InstrDone,
      input  Retired,
      input  State
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Control FSM for a multicycle MIPS-style datapath supporting
//                R-type, lw, sw, beq, j and addi. Produces the per-state
//                control strobes, flags unsupported opcodes, pulses
//                InstrDone when an instruction completes and counts retired
//                instructions.
//  Ports       : clk  - clock, all state changes on the rising edge
//                rst  - asynchronous active-low reset
//                bus  - multicycle_control_if.master (opcode, memory
//                       handshake, control strobes, status)
//  Parameters  : RETIRED_W - width of the retired-instruction counter
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
   parameter int RETIRED_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_control_if.master  bus
);

   // ---------------------------------------------------------------------
   // State encoding (12-15 unused; they fall back to FETCH)
   // ---------------------------------------------------------------------
   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_ADDI_EXEC = 4'd10;
   localparam logic [3:0] S_ADDI_WB   = 4'd11;

   // ---------------------------------------------------------------------
   // Supported opcodes (instruction bits [31:26])
   // ---------------------------------------------------------------------
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [3:0]           state_q,   state_d;
   // The opcode is only looked at in DECODE, so the lw/sw choice made there
   // is remembered for the MEM_ADDR branch instead of re-reading Opcode.
   logic                 store_q,   store_d;
   logic [RETIRED_W-1:0] retired_q, retired_d;

   // ---------------------------------------------------------------------
   // Combinational control, before reset gating
   // ---------------------------------------------------------------------
   logic [1:0] w_alu_op;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_pc_source;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_reg_write;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_iord;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_illegal;
   logic       w_instr_done;
   logic       w_op_supported;

   // ---------------------------------------------------------------------
   // Opcode legality
   // ---------------------------------------------------------------------
   always_comb begin
      w_op_supported = 1'b0;
      case (bus.Opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_op_supported = 1'b1;
         default:                                       w_op_supported = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      case (state_q)
         S_FETCH: begin
            if (bus.MemoryReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (bus.Opcode)
               OP_LW: begin
                  state_d = S_MEM_ADDR;
                  store_d = 1'b0;
               end
               OP_SW: begin
                  state_d = S_MEM_ADDR;
                  store_d = 1'b1;
               end
               OP_RTYPE: state_d = S_R_EXEC;
               OP_BEQ:   state_d = S_BRANCH;
               OP_J:     state_d = S_JUMP;
               OP_ADDI:  state_d = S_ADDI_EXEC;
               default:  state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            state_d = store_q ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            if (bus.MemoryReady) state_d = S_MEM_WB;
         end
         S_MEM_WRITE: begin
            if (bus.MemoryReady) state_d = S_FETCH;
         end
         S_R_EXEC:    state_d = S_R_WB;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode: everything defaults to 0, each state raises only its own
   // strobes. Strobes that depend on MemoryReady follow it in the same cycle
   // so a stalled access leaves the state's outputs unchanged.
   // ---------------------------------------------------------------------
   always_comb begin
      w_alu_op        = 2'b00;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_pc_source     = 2'b00;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_reg_write     = 1'b0;
      w_reg_dst       = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_iord          = 1'b0;
      w_ir_write      = 1'b0;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_illegal       = 1'b0;
      w_instr_done    = 1'b0;
      case (state_q)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            w_ir_write  = bus.MemoryReady;
            w_pc_write  = bus.MemoryReady;
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            w_illegal   = ~w_op_supported;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_alu_op    = 2'b00;
         end
         S_MEM_READ: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         S_MEM_WRITE: begin
            w_mem_write  = 1'b1;
            w_iord       = 1'b1;
            w_instr_done = bus.MemoryReady;
         end
         S_MEM_WB: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         S_R_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b10;
         end
         S_R_WB: begin
            w_reg_dst    = 1'b1;
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         S_ADDI_WB: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'b01;
            w_instr_done    = 1'b1;
         end
         S_JUMP: begin
            w_pc_write   = 1'b1;
            w_pc_source  = 2'b10;
            w_instr_done = 1'b1;
         end
         default: begin
            // unreachable encodings drive nothing
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Retired-instruction counter, wraps naturally at all-ones
   // ---------------------------------------------------------------------
   always_comb begin
      retired_d = retired_q;
      if (w_instr_done) retired_d = retired_q + RETIRED_W'(1);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         store_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         store_q   <= store_d;
         retired_q <= retired_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs. While reset is held the FSM sits in FETCH, whose strobes would
   // otherwise be active, so every control/status output is gated with rst.
   // This also kills any write strobe of an interrupted instruction at once.
   // ---------------------------------------------------------------------
   assign bus.ALUOpcode        = rst ? w_alu_op    : 2'b00;
   assign bus.ALUSrcA          = rst & w_alu_src_a;
   assign bus.ALUSrcB          = rst ? w_alu_src_b : 2'b00;
   assign bus.PCSource         = rst ? w_pc_source : 2'b00;
   assign bus.MemoryRead       = rst & w_mem_read;
   assign bus.MemoryWrite      = rst & w_mem_write;
   assign bus.RegisterWrite    = rst & w_reg_write;
   assign bus.RegistroDestino  = rst & w_reg_dst;
   assign bus.MemoryToRegister = rst & w_mem_to_reg;
   assign bus.IorD             = rst & w_iord;
   assign bus.IRWrite          = rst & w_ir_write;
   assign bus.PCWrite          = rst & w_pc_write;
   assign bus.PCWriteCond      = rst & w_pc_write_cond;
   assign bus.Illegal          = rst & w_illegal;
   assign bus.InstrDone        = rst & w_instr_done;
   assign bus.Retired          = retired_q;
   assign bus.State            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control. Each
//                step drives Opcode/MemoryReady on the falling edge and
//                compares State, the packed control word and Retired against
//                hand-derived values before the next rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

   // A narrow counter keeps the wrap-around check short.
   localparam int RW = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   // Control word layout:
   // {ALUOpcode[1:0], ALUSrcA, ALUSrcB[1:0], PCSource[1:0], MemoryRead,
   //  MemoryWrite, RegisterWrite, RegistroDestino, MemoryToRegister, IorD,
   //  IRWrite, PCWrite, PCWriteCond, Illegal, InstrDone}
   function automatic logic [17:0] mk(
      input logic [1:0] aluop, input logic srca, input logic [1:0] srcb,
      input logic [1:0] pcsrc, input logic mrd, input logic mwr,
      input logic rw, input logic rd, input logic m2r, input logic iord,
      input logic irw, input logic pcw, input logic pcwc,
      input logic ill, input logic done);
      return {aluop, srca, srcb, pcsrc, mrd, mwr, rw, rd, m2r, iord,
              irw, pcw, pcwc, ill, done};
   endfunction

   localparam logic [17:0] E_ZERO       = 18'd0;
   localparam logic [17:0] E_FETCH_RDY  = mk(2'd0,1'b0,2'd1,2'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_FETCH_WAIT = mk(2'd0,1'b0,2'd1,2'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_DECODE     = mk(2'd0,1'b0,2'd3,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_DECODE_ILL = mk(2'd0,1'b0,2'd3,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,1'b0);
   localparam logic [17:0] E_ADDR       = mk(2'd0,1'b1,2'd2,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_MEM_READ   = mk(2'd0,1'b0,2'd0,2'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_MEM_WB     = mk(2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b1);
   localparam logic [17:0] E_MW_WAIT    = mk(2'd0,1'b0,2'd0,2'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_MW_RDY     = mk(2'd0,1'b0,2'd0,2'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b1);
   localparam logic [17:0] E_R_EXEC     = mk(2'd2,1'b1,2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0);
   localparam logic [17:0] E_R_WB       = mk(2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b1);
   localparam logic [17:0] E_ADDI_WB    = mk(2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b1);
   localparam logic [17:0] E_BRANCH     = mk(2'd1,1'b1,2'd0,2'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 1'b0,1'b1);
   localparam logic [17:0] E_JUMP       = mk(2'd0,1'b0,2'd0,2'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1);

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   multicycle_control_if #(.RETIRED_W(RW)) bus ();

   multicycle_control #(.RETIRED_W(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [17:0] ctl_now();
      return {bus.ALUOpcode, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
              bus.MemoryRead, bus.MemoryWrite, bus.RegisterWrite,
              bus.RegistroDestino, bus.MemoryToRegister, bus.IorD,
              bus.IRWrite, bus.PCWrite, bus.PCWriteCond,
              bus.Illegal, bus.InstrDone};
   endfunction

   task automatic chk(input string tag, input logic [31:0] observed,
                      input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Called on a falling edge: drive inputs, let outputs settle, compare,
   // then advance to the next falling edge (one rising edge in between).
   task automatic step(input string tag, input logic mr, input logic [5:0] op,
                       input logic [3:0] exp_state, input logic [17:0] exp_ctl,
                       input logic [RW-1:0] exp_ret);
      bus.MemoryReady = mr;
      bus.Opcode      = op;
      #1;
      chk({tag, ".state"},   32'(bus.State),   32'(exp_state));
      chk({tag, ".ctl"},     32'(ctl_now()),   32'(exp_ctl));
      chk({tag, ".retired"}, 32'(bus.Retired), 32'(exp_ret));
      chk({tag, ".rd_wr_excl"}, 32'(bus.MemoryRead & bus.MemoryWrite), 32'd0);
      chk({tag, ".rw_wr_excl"}, 32'(bus.RegisterWrite & bus.MemoryWrite), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      rst             = 1'b0;
      bus.MemoryReady = 1'b1;
      bus.Opcode      = OP_LW;

      // Reset: FETCH with MemoryReady=1 would raise strobes, but all are held low.
      @(negedge clk);
      #1;
      chk("reset.state",   32'(bus.State),   32'd0);
      chk("reset.ctl",     32'(ctl_now()),   32'(E_ZERO));
      chk("reset.retired", 32'(bus.Retired), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // lw, no stalls: 0,1,2,3,4 then FETCH with Retired=1. Opcode scrambled
      // after DECODE to show it is not re-sampled.
      step("lw.fetch",  1'b1, OP_LW,   4'd0, E_FETCH_RDY, 4'd0);
      step("lw.decode", 1'b1, OP_LW,   4'd1, E_DECODE,    4'd0);
      step("lw.addr",   1'b1, OP_SW,   4'd2, E_ADDR,      4'd0);
      step("lw.read",   1'b1, OP_BAD,  4'd3, E_MEM_READ,  4'd0);
      step("lw.wb",     1'b1, OP_BAD,  4'd4, E_MEM_WB,    4'd0);

      // sw with three stalled MEM_WRITE cycles: 7 cycles total.
      step("sw.fetch",  1'b1, OP_SW,    4'd0, E_FETCH_RDY, 4'd1);
      step("sw.decode", 1'b1, OP_SW,    4'd1, E_DECODE,    4'd1);
      step("sw.addr",   1'b1, OP_LW,    4'd2, E_ADDR,      4'd1);
      step("sw.wait1",  1'b0, OP_RTYPE, 4'd5, E_MW_WAIT,   4'd1);
      step("sw.wait2",  1'b0, OP_RTYPE, 4'd5, E_MW_WAIT,   4'd1);
      step("sw.wait3",  1'b0, OP_RTYPE, 4'd5, E_MW_WAIT,   4'd1);
      step("sw.done",   1'b1, OP_RTYPE, 4'd5, E_MW_RDY,    4'd1);

      // FETCH stall, then R-type (4 cycles).
      step("r.fwait",   1'b0, OP_RTYPE, 4'd0, E_FETCH_WAIT, 4'd2);
      step("r.fetch",   1'b1, OP_RTYPE, 4'd0, E_FETCH_RDY,  4'd2);
      step("r.decode",  1'b1, OP_RTYPE, 4'd1, E_DECODE,     4'd2);
      step("r.exec",    1'b1, OP_BAD,   4'd6, E_R_EXEC,     4'd2);
      step("r.wb",      1'b1, OP_BAD,   4'd7, E_R_WB,       4'd2);

      // beq (3 cycles) and j (3 cycles).
      step("beq.fetch",  1'b1, OP_BEQ, 4'd0, E_FETCH_RDY, 4'd3);
      step("beq.decode", 1'b1, OP_BEQ, 4'd1, E_DECODE,    4'd3);
      step("beq.branch", 1'b1, OP_BAD, 4'd8, E_BRANCH,    4'd3);
      step("j.fetch",    1'b1, OP_J,   4'd0, E_FETCH_RDY, 4'd4);
      step("j.decode",   1'b1, OP_J,   4'd1, E_DECODE,    4'd4);
      step("j.jump",     1'b1, OP_BAD, 4'd9, E_JUMP,      4'd4);

      // Illegal opcode: 2 cycles, no InstrDone, Retired stays at 5.
      step("ill.fetch",  1'b1, OP_BAD, 4'd0, E_FETCH_RDY,  4'd5);
      step("ill.decode", 1'b1, OP_BAD, 4'd1, E_DECODE_ILL, 4'd5);

      // lw with one stalled MEM_READ cycle.
      step("lw2.fetch",  1'b1, OP_LW,   4'd0, E_FETCH_RDY, 4'd5);
      step("lw2.decode", 1'b1, OP_LW,   4'd1, E_DECODE,    4'd5);
      step("lw2.addr",   1'b1, OP_LW,   4'd2, E_ADDR,      4'd5);
      step("lw2.rwait",  1'b0, OP_LW,   4'd3, E_MEM_READ,  4'd5);
      step("lw2.read",   1'b1, OP_LW,   4'd3, E_MEM_READ,  4'd5);
      step("lw2.wb",     1'b1, OP_LW,   4'd4, E_MEM_WB,    4'd5);

      // sw interrupted by reset while stalled in MEM_WRITE.
      step("sw2.fetch",  1'b1, OP_SW, 4'd0, E_FETCH_RDY, 4'd6);
      step("sw2.decode", 1'b1, OP_SW, 4'd1, E_DECODE,    4'd6);
      step("sw2.addr",   1'b1, OP_SW, 4'd2, E_ADDR,      4'd6);
      step("sw2.wait",   1'b0, OP_SW, 4'd5, E_MW_WAIT,   4'd6);
      rst = 1'b0;
      #1;
      chk("midrst.state",   32'(bus.State),       32'd0);
      chk("midrst.mwrite",  32'(bus.MemoryWrite), 32'd0);
      chk("midrst.ctl",     32'(ctl_now()),       32'(E_ZERO));
      chk("midrst.retired", 32'(bus.Retired),     32'd0);
      @(negedge clk);
      bus.MemoryReady = 1'b1;
      #1;
      chk("midrst.hold_ctl", 32'(ctl_now()), 32'(E_ZERO));
      @(negedge clk);
      rst = 1'b1;

      // 16 addi instructions on a 4-bit counter: 15 -> 0 on the last one.
      for (int i = 0; i < 16; i++) begin
         step("addi.fetch",  1'b1, OP_ADDI, 4'd0,  E_FETCH_RDY, RW'(i));
         step("addi.decode", 1'b1, OP_ADDI, 4'd1,  E_DECODE,    RW'(i));
         step("addi.exec",   1'b1, OP_BAD,  4'd10, E_ADDR,      RW'(i));
         step("addi.wb",     1'b1, OP_BAD,  4'd11, E_ADDI_WB,   RW'(i));
      end
      step("wrap.fetch", 1'b1, OP_RTYPE, 4'd0, E_FETCH_RDY, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: RETIRED_W, default 16, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 Opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-005 MemoryReady  in  1  memory handshake; 1 = current access completes this cycle.
REQ-006 Control outputs, each driven out:
- ALUOpcode (2)
- ALUSrcA (1)
- ALUSrcB (2)
- PCSource (2)
- MemoryRead, MemoryWrite, RegisterWrite, RegistroDestino, MemoryToRegister, IorD, IRWrite, PCWrite, PCWriteCond (1 each)
REQ-007 Status outputs:
- Illegal  out  1  unsupported opcode pulse
- InstrDone  out  1  instruction-complete pulse
- Retired  out  RETIRED_W  completed-instruction count
- State  out  4  current FSM state

Function
REQ-008 Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; 12-15 unreachable, treated as FETCH next cycle.
REQ-009 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-010 Opcode is sampled only in DECODE.
REQ-011 Transitions:
- FETCH->DECODE when MemoryReady=1, else hold.
- DECODE->MEM_ADDR (lw/sw), R_EXEC, BRANCH, JUMP, ADDI_EXEC, or FETCH (unsupported).
- MEM_ADDR->MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ->MEM_WB when MemoryReady=1, else hold.
- MEM_WRITE->FETCH when MemoryReady=1, else hold.
- R_EXEC->R_WB; ADDI_EXEC->ADDI_WB.
- MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP -> FETCH.
REQ-012 Every output not listed for a state SHALL be 0.
REQ-013 FETCH: MemoryRead=1, ALUSrcB=01; IRWrite=1 and PCWrite=1 only while MemoryReady=1.
REQ-014 DECODE: ALUSrcB=11.
REQ-015 MEM_ADDR and ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOpcode=00.
REQ-016 MEM_READ: MemoryRead=1, IorD=1.
REQ-017 MEM_WRITE: MemoryWrite=1, IorD=1.
REQ-018 MEM_WB: MemoryToRegister=1, RegisterWrite=1.
REQ-019 R_EXEC: ALUSrcA=1, ALUOpcode=10.
REQ-020 R_WB: RegistroDestino=1, RegisterWrite=1.
REQ-021 ADDI_WB: RegisterWrite=1.
REQ-022 BRANCH: ALUSrcA=1, ALUOpcode=01, PCWriteCond=1, PCSource=01.
REQ-023 JUMP: PCWrite=1, PCSource=10.
REQ-024 Illegal=1 for exactly the DECODE cycle in which Opcode is unsupported.
REQ-025 InstrDone=1 for one cycle in each of MEM_WB, R_WB, ADDI_WB, BRANCH and JUMP, and in MEM_WRITE only when MemoryReady=1.
REQ-026 Illegal instructions SHALL NOT assert InstrDone.
REQ-027 Retired increments by 1 on each clock edge where InstrDone=1, and wraps from all-ones to 0.
REQ-028 Latency in cycles with MemoryReady held at 1, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-029 Each MemoryReady=0 cycle in a waiting state (FETCH, MEM_READ, MEM_WRITE) adds exactly one cycle; the outputs of that state are held unchanged.
REQ-030 MemoryRead and MemoryWrite SHALL never both be 1.
REQ-031 RegisterWrite and MemoryWrite SHALL never both be 1.

Reset
REQ-032 When rst=0: State=FETCH and Retired=0 immediately, and all control and status outputs are forced to 0.
REQ-033 After rst rises, the first clock edge evaluates FETCH normally.
REQ-034 Reset asserted mid-instruction SHALL abort the instruction with no further RegisterWrite, MemoryWrite or InstrDone, and SHALL NOT increment Retired.

Verification
REQ-035 Reset release, MemoryReady=1, Opcode=100011 -> State sequence 0,1,2,3,4,0; RegisterWrite=1 and MemoryToRegister=1 only in state 4; Retired=1.
REQ-036 Opcode=101011 with MemoryReady=0 for 3 cycles in MEM_WRITE -> MemoryWrite=1 and IorD=1 held for 4 cycles; InstrDone=1 on the 4th; total 7 cycles.
REQ-037 Opcode=000000 then 000100 then 000010 -> cycle counts 4, 3, 3; ALUOpcode 10 in R_EXEC, 01 in BRANCH; PCSource 10 in JUMP; Retired=3.
REQ-038 Opcode=111111 -> Illegal=1 for one cycle in state 1, return to state 0, Retired unchanged.
REQ-039 rst pulled to 0 while State=5 -> State=0 and MemoryWrite=0 asynchronously, Retired=0.
REQ-040 Preload Retired to all-ones via 65535 addi instructions (or a forced value) and complete one more -> Retired=0.
